// File: rtl/adder_entry_ctrl.sv
// -----------------------------------------------------------------------------
// adder_entry_ctrl
//
// Keypad-entry sequencer for the two-operand shift/add datapath. Debounced key
// presses are turned into the sequence "A digit, '+', B digit, '='". Digits are
// pushed into the datapath with a one-cycle shift strobe. On '=' the 5-bit
// datapath sum is latched as two BCD digits and shown for HOLD_CYCLES cycles.
// Clear pushes two zeros through the datapath. Illegal keys raise a one-cycle
// key_err pulse.
//
// Ports:
//   clk          in   system clock, all state updates on the rising edge
//   rst          in   synchronous active-high reset
//   key_press    in   debounced key-down level
//   key_code[3:0]in   code of the pressed key, valid while key_press=1
//   sum_in[4:0]  in   sum output from the datapath
//   shift_valid  out  one-cycle shift strobe to the datapath
//   key_out[3:0] out  value presented to the datapath key input
//   result_valid out  high while the result is shown
//   sum_tens[3:0]out  BCD tens of the latched sum
//   sum_ones[3:0]out  BCD ones of the latched sum
//   key_err      out  one-cycle pulse on an illegal key
//   state_o[2:0] out  current state encoding for debug LEDs
// -----------------------------------------------------------------------------
module adder_entry_ctrl #(
  parameter int unsigned HOLD_CYCLES = 100000000,
  parameter logic [3:0]  KEY_ADD     = 4'hA,
  parameter logic [3:0]  KEY_EQ      = 4'hE,
  parameter logic [3:0]  KEY_CLR     = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_press,
  input  logic [3:0] key_code,
  input  logic [4:0] sum_in,
  output logic       shift_valid,
  output logic [3:0] key_out,
  output logic       result_valid,
  output logic [3:0] sum_tens,
  output logic [3:0] sum_ones,
  output logic       key_err,
  output logic [2:0] state_o
);

  localparam int unsigned CW = (HOLD_CYCLES > 32'd1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 32'd1);

  typedef enum logic [2:0] {
    S_CLR1    = 3'd0,
    S_CLR2    = 3'd1,
    S_WAIT_A  = 3'd2,
    S_WAIT_OP = 3'd3,
    S_WAIT_B  = 3'd4,
    S_WAIT_EQ = 3'd5,
    S_SHOW    = 3'd6
  } state_t;

  // Splits a datapath sum (0..30) into BCD tens/ones, packed {tens, ones}.
  function automatic logic [7:0] to_bcd(input logic [4:0] v);
    logic [4:0] r;
    if (v >= 5'd20) begin
      r = v - 5'd20;
      to_bcd = {4'd2, r[3:0]};
    end else if (v >= 5'd10) begin
      r = v - 5'd10;
      to_bcd = {4'd1, r[3:0]};
    end else begin
      r = v;
      to_bcd = {4'd0, r[3:0]};
    end
  endfunction

  state_t        state_q, state_d;
  logic          kp_q, kp_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          shift_valid_q, shift_valid_d;
  logic [3:0]    key_out_q, key_out_d;
  logic          key_err_q, key_err_d;
  logic          result_valid_q, result_valid_d;
  logic [3:0]    sum_tens_q, sum_tens_d;
  logic [3:0]    sum_ones_q, sum_ones_d;

  logic          edge_s;
  logic          is_digit_s;
  logic          is_add_s;
  logic          is_eq_s;
  logic          is_clr_s;
  logic [7:0]    bcd_s;

  assign edge_s     = key_press & ~kp_q;
  assign is_digit_s = (key_code <= 4'd9);
  assign is_add_s   = (key_code == KEY_ADD);
  assign is_eq_s    = (key_code == KEY_EQ);
  assign is_clr_s   = (key_code == KEY_CLR);
  assign bcd_s      = to_bcd(sum_in);

  // Next-state and next-output logic for the entry sequencer.
  always_comb begin
    state_d       = state_q;
    kp_d          = key_press;
    hold_cnt_d    = hold_cnt_q;
    shift_valid_d = 1'b0;
    key_out_d     = key_out_q;
    key_err_d     = 1'b0;
    sum_tens_d    = sum_tens_q;
    sum_ones_d    = sum_ones_q;

    case (state_q)
      // Two zero shifts flush both datapath operands; keys are ignored.
      S_CLR1: begin
        shift_valid_d = 1'b1;
        key_out_d     = 4'd0;
        state_d       = S_CLR2;
      end

      S_CLR2: begin
        shift_valid_d = 1'b1;
        key_out_d     = 4'd0;
        state_d       = S_WAIT_A;
      end

      S_WAIT_A: begin
        if (!edge_s) begin
          state_d = S_WAIT_A;
        end else if (is_digit_s) begin
          shift_valid_d = 1'b1;
          key_out_d     = key_code;
          state_d       = S_WAIT_OP;
        end else if (is_clr_s) begin
          state_d = S_CLR1;
        end else begin
          key_err_d = 1'b1;
        end
      end

      // A further digit replaces A; the previous A moves into the augend
      // slot and is pushed out by the B shift.
      S_WAIT_OP: begin
        if (!edge_s) begin
          state_d = S_WAIT_OP;
        end else if (is_add_s) begin
          state_d = S_WAIT_B;
        end else if (is_digit_s) begin
          shift_valid_d = 1'b1;
          key_out_d     = key_code;
        end else if (is_clr_s) begin
          state_d = S_CLR1;
        end else begin
          key_err_d = 1'b1;
        end
      end

      S_WAIT_B: begin
        if (!edge_s) begin
          state_d = S_WAIT_B;
        end else if (is_digit_s) begin
          shift_valid_d = 1'b1;
          key_out_d     = key_code;
          state_d       = S_WAIT_EQ;
        end else if (is_clr_s) begin
          state_d = S_CLR1;
        end else begin
          key_err_d = 1'b1;
        end
      end

      // Keys are at least two cycles apart, so the B shift has settled in
      // the datapath by the time '=' can be seen here.
      S_WAIT_EQ: begin
        if (!edge_s) begin
          state_d = S_WAIT_EQ;
        end else if (is_eq_s) begin
          sum_tens_d = bcd_s[7:4];
          sum_ones_d = bcd_s[3:0];
          hold_cnt_d = '0;
          state_d    = S_SHOW;
        end else if (is_clr_s) begin
          state_d = S_CLR1;
        end else begin
          key_err_d = 1'b1;
        end
      end

      // A key edge takes priority over the hold timeout in the same cycle.
      S_SHOW: begin
        hold_cnt_d = hold_cnt_q + CW'(1);
        if (edge_s) begin
          if (is_digit_s) begin
            shift_valid_d = 1'b1;
            key_out_d     = key_code;
            state_d       = S_WAIT_OP;
          end else if (is_clr_s) begin
            state_d = S_CLR1;
          end else begin
            key_err_d = 1'b1;
          end
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = S_CLR1;
        end else begin
          state_d = S_SHOW;
        end
      end

      default: begin
        state_d = S_CLR1;
      end
    endcase

    // Registered so that result_valid tracks the state register exactly.
    result_valid_d = (state_d == S_SHOW);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_CLR1;
      kp_q           <= 1'b0;
      hold_cnt_q     <= '0;
      shift_valid_q  <= 1'b0;
      key_out_q      <= 4'd0;
      key_err_q      <= 1'b0;
      result_valid_q <= 1'b0;
      sum_tens_q     <= 4'd0;
      sum_ones_q     <= 4'd0;
    end else begin
      state_q        <= state_d;
      kp_q           <= kp_d;
      hold_cnt_q     <= hold_cnt_d;
      shift_valid_q  <= shift_valid_d;
      key_out_q      <= key_out_d;
      key_err_q      <= key_err_d;
      result_valid_q <= result_valid_d;
      sum_tens_q     <= sum_tens_d;
      sum_ones_q     <= sum_ones_d;
    end
  end

  assign shift_valid  = shift_valid_q;
  assign key_out      = key_out_q;
  assign key_err      = key_err_q;
  assign result_valid = result_valid_q;
  assign sum_tens     = sum_tens_q;
  assign sum_ones     = sum_ones_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_adder_entry_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adder_entry_ctrl
//
// Directed bench for adder_entry_ctrl. A small two-register shift datapath
// model supplies sum_in. Each check is an immediate assertion against a
// hand-computed value.
// -----------------------------------------------------------------------------
module tb_adder_entry_ctrl;

  logic       clk;
  logic       rst;
  logic       key_press;
  logic [3:0] key_code;
  logic [4:0] sum_in;
  logic       shift_valid;
  logic [3:0] key_out;
  logic       result_valid;
  logic [3:0] sum_tens;
  logic [3:0] sum_ones;
  logic       key_err;
  logic [2:0] state_o;

  int n_assert = 0;
  int n_fail   = 0;
  int shift_cnt = 0;

  // Datapath model: augend <- addend <- key on each shift strobe.
  logic [3:0] aug_m = 4'd0;
  logic [3:0] add_m = 4'd0;

  // Values captured right after the action edge of a key press.
  logic       cap_sv, cap_ke, cap_rv, cap_sv2, cap_ke2;
  logic [3:0] cap_ko;
  logic [2:0] cap_st;

  adder_entry_ctrl #(
    .HOLD_CYCLES(10),
    .KEY_ADD    (4'hA),
    .KEY_EQ     (4'hE),
    .KEY_CLR    (4'hF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_press   (key_press),
    .key_code    (key_code),
    .sum_in      (sum_in),
    .shift_valid (shift_valid),
    .key_out     (key_out),
    .result_valid(result_valid),
    .sum_tens    (sum_tens),
    .sum_ones    (sum_ones),
    .key_err     (key_err),
    .state_o     (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (shift_valid) begin
      aug_m     <= add_m;
      add_m     <= key_out;
      shift_cnt <= shift_cnt + 1;
    end
  end

  assign sum_in = {1'b0, aug_m} + {1'b0, add_m};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Press a key, sample outputs after the action edge and one cycle later,
  // hold for 'hold' extra cycles, then release for one cycle.
  task automatic press(input logic [3:0] code, input int hold);
    key_code  = code;
    key_press = 1'b1;
    tick();
    cap_sv = shift_valid;
    cap_ko = key_out;
    cap_ke = key_err;
    cap_st = state_o;
    cap_rv = result_valid;
    tick();
    cap_sv2 = shift_valid;
    cap_ke2 = key_err;
    repeat (hold) tick();
    key_press = 1'b0;
    key_code  = 4'd0;
    tick();
  endtask

  initial begin
    int n;
    int sc0;
    rst       = 1'b1;
    key_press = 1'b0;
    key_code  = 4'd0;
    repeat (3) tick();

    // Reset state
    chk("rst_sv",    32'(shift_valid),  32'd0);
    chk("rst_ko",    32'(key_out),      32'd0);
    chk("rst_rv",    32'(result_valid), 32'd0);
    chk("rst_ke",    32'(key_err),      32'd0);
    chk("rst_tens",  32'(sum_tens),     32'd0);
    chk("rst_ones",  32'(sum_ones),     32'd0);
    chk("rst_state", 32'(state_o),      32'd0);

    // Release: two zero shifts, state 0 -> 1 -> 2
    rst = 1'b0;
    tick();
    chk("clr1_sv", 32'(shift_valid), 32'd1);
    chk("clr1_ko", 32'(key_out),     32'd0);
    chk("clr1_st", 32'(state_o),     32'd1);
    tick();
    chk("clr2_sv", 32'(shift_valid), 32'd1);
    chk("clr2_ko", 32'(key_out),     32'd0);
    chk("clr2_st", 32'(state_o),     32'd2);
    tick();
    chk("wa_sv", 32'(shift_valid), 32'd0);
    chk("wa_st", 32'(state_o),     32'd2);
    chk("wa_ke", 32'(key_err),     32'd0);

    // 7 + 8 = 15
    press(4'd7, 0);
    chk("k7_sv",  32'(cap_sv),  32'd1);
    chk("k7_ko",  32'(cap_ko),  32'd7);
    chk("k7_st",  32'(cap_st),  32'd3);
    chk("k7_sv2", 32'(cap_sv2), 32'd0);
    press(4'hA, 0);
    chk("kA_sv", 32'(cap_sv), 32'd0);
    chk("kA_ko", 32'(cap_ko), 32'd7);
    chk("kA_st", 32'(cap_st), 32'd4);
    press(4'd8, 0);
    chk("k8_sv", 32'(cap_sv), 32'd1);
    chk("k8_ko", 32'(cap_ko), 32'd8);
    chk("k8_st", 32'(cap_st), 32'd5);
    press(4'hE, 0);
    chk("e15_st",   32'(cap_st),   32'd6);
    chk("e15_rv",   32'(cap_rv),   32'd1);
    chk("e15_sv",   32'(cap_sv),   32'd0);
    chk("e15_tens", 32'(sum_tens), 32'd1);
    chk("e15_ones", 32'(sum_ones), 32'd5);

    // From SHOW: 3, 4 (replaces A), +, 9, = -> 4 + 9 = 13
    press(4'd3, 0);
    chk("s3_sv", 32'(cap_sv), 32'd1);
    chk("s3_ko", 32'(cap_ko), 32'd3);
    chk("s3_st", 32'(cap_st), 32'd3);
    chk("s3_rv", 32'(cap_rv), 32'd0);
    press(4'd4, 0);
    chk("r4_ko", 32'(cap_ko), 32'd4);
    chk("r4_st", 32'(cap_st), 32'd3);
    press(4'hA, 0);
    press(4'd9, 0);
    chk("b9_ko", 32'(cap_ko), 32'd9);
    chk("b9_st", 32'(cap_st), 32'd5);
    press(4'hE, 0);
    chk("e13_st",   32'(cap_st),   32'd6);
    chk("e13_tens", 32'(sum_tens), 32'd1);
    chk("e13_ones", 32'(sum_ones), 32'd3);

    // Clear from SHOW: two zero shifts flush the datapath
    press(4'hF, 0);
    chk("f_ke", 32'(cap_ke), 32'd0);
    chk("f_st", 32'(cap_st), 32'd0);
    tick();
    tick();
    chk("f_st2",  32'(state_o),  32'd2);
    chk("f_dp",   32'(sum_in),   32'd0);
    chk("f_tens", 32'(sum_tens), 32'd1);
    chk("f_ones", 32'(sum_ones), 32'd3);

    // Illegal keys in WAIT_A
    press(4'hE, 0);
    chk("wa_e_ke",  32'(cap_ke),  32'd1);
    chk("wa_e_sv",  32'(cap_sv),  32'd0);
    chk("wa_e_st",  32'(cap_st),  32'd2);
    chk("wa_e_ke2", 32'(cap_ke2), 32'd0);
    press(4'hC, 0);
    chk("wa_c_ke", 32'(cap_ke), 32'd1);
    chk("wa_c_sv", 32'(cap_sv), 32'd0);
    chk("wa_c_st", 32'(cap_st), 32'd2);

    // Holding 5 for ~50 cycles gives one shift only
    sc0 = shift_cnt;
    press(4'd5, 48);
    chk("hold_ko",  32'(cap_ko),        32'd5);
    chk("hold_st",  32'(state_o),       32'd3);
    chk("hold_cnt", 32'(shift_cnt - sc0), 32'd1);

    // 2, +, clear
    press(4'd2, 0);
    chk("c2_st", 32'(cap_st), 32'd3);
    press(4'hA, 0);
    chk("cA_st", 32'(cap_st), 32'd4);
    press(4'hF, 0);
    chk("cF_st", 32'(cap_st), 32'd0);
    chk("cF_ke", 32'(cap_ke), 32'd0);
    tick();
    tick();
    chk("cF_dp", 32'(sum_in), 32'd0);

    // 9 + 9 = 18, then timeout after 10 cycles in SHOW
    press(4'd9, 0);
    press(4'hA, 0);
    press(4'd9, 0);
    press(4'hE, 0);
    chk("e18_st",   32'(cap_st),   32'd6);
    chk("e18_tens", 32'(sum_tens), 32'd1);
    chk("e18_ones", 32'(sum_ones), 32'd8);
    chk("e18_rv",   32'(result_valid), 32'd1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (state_o == 3'd0) break;
    end
    // Action edge plus the two edges inside press(): 8 more to reach 10
    chk("to_cycles", 32'(n),            32'd8);
    chk("to_state",  32'(state_o),      32'd0);
    chk("to_rv",     32'(result_valid), 32'd0);
    tick();
    tick();
    chk("to_wa", 32'(state_o), 32'd2);

    // Reset mid-entry in WAIT_B
    press(4'd1, 0);
    press(4'hA, 0);
    chk("wb_st", 32'(cap_st), 32'd4);
    rst = 1'b1;
    tick();
    chk("mr_st",   32'(state_o),      32'd0);
    chk("mr_sv",   32'(shift_valid),  32'd0);
    chk("mr_ko",   32'(key_out),      32'd0);
    chk("mr_rv",   32'(result_valid), 32'd0);
    chk("mr_ke",   32'(key_err),      32'd0);
    chk("mr_tens", 32'(sum_tens),     32'd0);
    chk("mr_ones", 32'(sum_ones),     32'd0);
    rst = 1'b0;
    tick();
    chk("mr1_sv", 32'(shift_valid), 32'd1);
    chk("mr1_ko", 32'(key_out),     32'd0);
    chk("mr1_st", 32'(state_o),     32'd1);
    tick();
    chk("mr2_sv", 32'(shift_valid), 32'd1);
    chk("mr2_st", 32'(state_o),     32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
